// File: rtl/serial2parallel.sv
// Serial-to-parallel deserialiser: rebuilds N-bit words from a framed bit stream
// and presents them on a valid/ready port, flagging malformed frames and overruns.
module serial2parallel #(
  parameter int unsigned N         = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         d,
  input  logic         serial_start,
  input  logic         serial_end,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         frame_err,
  output logic         overrun,
  output logic [3:0]   bit_count
);

  localparam int unsigned IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [3:0]  LAST = 4'(N - 1);
  localparam logic [IW-1:0] FIRST_POS = LSB_FIRST ? IW'(0) : IW'(N - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]   state, state_n;
  logic [N-1:0] shift_q, shift_n;
  logic [3:0]   cnt_n;
  logic [N-1:0] out_n;
  logic         valid_n, ferr_n, ovr_n;
  logic         good_c;
  logic [IW-1:0] pos_c;
  logic [N-1:0] word_c, first_c;

  // Next-state, bit capture and output-port handshake
  always_comb begin
    state_n = state;
    shift_n = shift_q;
    cnt_n   = bit_count;
    out_n   = data_out;
    valid_n = data_valid;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    good_c  = 1'b0;

    pos_c = LSB_FIRST ? IW'(bit_count) : IW'(LAST - bit_count);
    word_c = shift_q;
    word_c[pos_c] = d;
    first_c = '0;
    first_c[FIRST_POS] = d;

    if (state == IDLE) begin
      if (serial_start) begin
        shift_n = first_c;
        cnt_n   = 4'd1;
        state_n = SHIFT;
      end
    end else begin
      if (serial_start) begin
        ferr_n  = 1'b1;
        shift_n = first_c;
        cnt_n   = 4'd1;
      end else if (serial_end) begin
        state_n = IDLE;
        cnt_n   = 4'd0;
        shift_n = '0;
        if (bit_count == LAST) good_c = 1'b1;
        else                   ferr_n = 1'b1;
      end else if (bit_count == LAST) begin
        ferr_n  = 1'b1;
        state_n = IDLE;
        cnt_n   = 4'd0;
        shift_n = '0;
      end else begin
        shift_n = word_c;
        cnt_n   = bit_count + 4'd1;
      end
    end

    // The output slot is free if empty or being drained this very cycle
    if (good_c) begin
      if (!data_valid || data_ready) begin
        out_n   = word_c;
        valid_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end else if (data_valid && data_ready) begin
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_count  <= 4'd0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      shift_q    <= shift_n;
      bit_count  <= cnt_n;
      data_out   <= out_n;
      data_valid <= valid_n;
      frame_err  <= ferr_n;
      overrun    <= ovr_n;
    end
  end

endmodule

// File: tb/tb_serial2parallel.sv
// Self-checking bench for serial2parallel: LSB-first and MSB-first instances share
// stimulus and are compared every cycle against a frame-level bit-queue model.
module tb_serial2parallel;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         d, serial_start, serial_end, data_ready;
  logic [N-1:0] data_out_l, data_out_m;
  logic         valid_l, valid_m, ferr_l, ferr_m, ovr_l, ovr_m;
  logic [3:0]   cnt_l, cnt_m;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit        in_frame;
  bit        q[$];
  logic [15:0] exp_out_l, exp_out_m;
  logic      exp_valid, exp_ferr, exp_ovr;
  logic [3:0] exp_cnt;

  always #5 clk = ~clk;

  serial2parallel #(.N(N), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .d(d), .serial_start(serial_start),
    .serial_end(serial_end), .data_out(data_out_l), .data_valid(valid_l),
    .data_ready(data_ready), .frame_err(ferr_l), .overrun(ovr_l), .bit_count(cnt_l)
  );

  serial2parallel #(.N(N), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .d(d), .serial_start(serial_start),
    .serial_end(serial_end), .data_out(data_out_m), .data_valid(valid_m),
    .data_ready(data_ready), .frame_err(ferr_m), .overrun(ovr_m), .bit_count(cnt_m)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock of the spec at frame level: a frame is the list of bits received so far
  task automatic model_step(input bit dv, sv, ev, rv, rst);
    bit good = 1'b0;
    logic [15:0] wl = '0;
    logic [15:0] wm = '0;
    if (rst) begin
      in_frame = 0; q.delete();
      exp_out_l = '0; exp_out_m = '0;
      exp_valid = 0; exp_ferr = 0; exp_ovr = 0; exp_cnt = '0;
      return;
    end
    exp_ferr = 0;
    exp_ovr  = 0;
    if (!in_frame) begin
      if (sv) begin q.delete(); q.push_back(dv); in_frame = 1; end
    end else if (sv) begin
      exp_ferr = 1; q.delete(); q.push_back(dv);
    end else begin
      q.push_back(dv);
      if (ev) begin
        if (q.size() == N) good = 1; else exp_ferr = 1;
        in_frame = 0;
      end else if (q.size() == N) begin
        exp_ferr = 1; in_frame = 0;
      end
    end
    if (good) begin
      for (int i = 0; i < int'(N); i++) begin
        wl += 16'(q[i]) * (16'd1 << i);
        wm += 16'(q[i]) * (16'd1 << (N - 1 - i));
      end
      if (!exp_valid || rv) begin
        exp_out_l = wl; exp_out_m = wm; exp_valid = 1;
      end else begin
        exp_ovr = 1;
      end
    end else if (exp_valid && rv) begin
      exp_valid = 0;
    end
    exp_cnt = in_frame ? 4'(q.size()) : 4'd0;
  endtask

  task automatic cyc(input bit dv, sv, ev, rv);
    d = dv; serial_start = sv; serial_end = ev; data_ready = rv;
    model_step(dv, sv, ev, rv, reset);
    @(posedge clk); #1;
    chk("data_out_lsb", 16'(data_out_l), exp_out_l);
    chk("data_out_msb", 16'(data_out_m), exp_out_m);
    chk("data_valid", 16'(valid_l), 16'(exp_valid));
    chk("data_valid_msb", 16'(valid_m), 16'(exp_valid));
    chk("frame_err", 16'(ferr_l), 16'(exp_ferr));
    chk("overrun", 16'(ovr_l), 16'(exp_ovr));
    chk("bit_count", 16'(cnt_l), 16'(exp_cnt));
    chk("frame_err_msb", 16'(ferr_m), 16'(exp_ferr));
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits, input bit with_end, input bit rv);
    for (int i = 0; i < nbits; i++)
      cyc(w[i], i == 0, with_end && (i == nbits - 1), rv);
  endtask

  initial begin
    int kind, len;
    logic [15:0] w;
    reset = 1'b1;
    d = 0; serial_start = 0; serial_end = 0; data_ready = 0;
    cyc(1, 1, 1, 1);
    chk("reset_valid", 16'(valid_l), 16'd0);
    chk("reset_out", 16'(data_out_l), 16'd0);
    reset = 1'b0;

    // Single good frame
    send_frame(16'hA5, 8, 1, 1);
    chk("a5_out", 16'(data_out_l), 16'h00A5);
    chk("a5_valid", 16'(valid_l), 16'd1);
    cyc(0, 0, 0, 1);
    chk("a5_drained", 16'(valid_l), 16'd0);

    // Back-to-back frames while downstream stalls
    send_frame(16'h3C, 8, 1, 0);
    send_frame(16'hC3, 8, 1, 0);
    chk("ovr_pulse", 16'(ovr_l), 16'd1);
    chk("ovr_keep", 16'(data_out_l), 16'h003C);
    cyc(0, 0, 0, 0);
    chk("ovr_once", 16'(ovr_l), 16'd0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("3c_drained", 16'(valid_l), 16'd0);

    // Short frame: end on bit 4
    send_frame(16'h1F, 5, 1, 1);
    chk("short_err", 16'(ferr_l), 16'd1);
    chk("short_cnt", 16'(cnt_l), 16'd0);

    // Long frame, then a good one
    send_frame(16'hFF, 8, 0, 1);
    chk("long_err", 16'(ferr_l), 16'd1);
    send_frame(16'h81, 8, 1, 1);
    chk("81_out", 16'(data_out_l), 16'h0081);

    // Restart at bit 3 followed by a complete frame
    send_frame(16'h07, 3, 0, 1);
    send_frame(16'h5A, 8, 1, 1);
    chk("5a_out", 16'(data_out_l), 16'h005A);
    cyc(0, 0, 0, 1);

    // MSB-first placement, then reset mid-frame
    send_frame(16'h01, 8, 1, 1);
    chk("msb_out", 16'(data_out_m), 16'h0080);
    cyc(0, 0, 0, 0);
    send_frame(16'h15, 5, 0, 0);
    reset = 1'b1;
    cyc(1, 0, 0, 0);
    reset = 1'b0;
    chk("rst_mid_cnt", 16'(cnt_l), 16'd0);
    chk("rst_mid_valid", 16'(valid_l), 16'd0);
    chk("rst_mid_err", 16'(ferr_l), 16'd0);

    // Randomized mix of good, short, long and restarted frames with random stalls
    for (int f = 0; f < 200; f++) begin
      kind = int'($urandom_range(0, 5));
      w = 16'($urandom);
      case (kind)
        0: begin len = int'($urandom_range(1, N - 1)); send_frame(w, len, 1, 1'($urandom)); end
        1: send_frame(w, N, 0, 1'($urandom));
        2: begin len = int'($urandom_range(1, N - 1)); send_frame(w, len, 0, 1'($urandom)); end
        default: send_frame(w, N, 1, 1'($urandom));
      endcase
      for (int g = int'($urandom_range(0, 2)); g > 0; g--)
        cyc(1'($urandom), 0, 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
